// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// ALU writeback path and the load unit. Each source has a small FIFO. One FIFO
// head is drained per cycle onto the registered WE3/AD3/WD3 port.
// Optional build macro RR_ARB_EN: contended grants alternate between the two
// sources. When it is undefined, the ALU has fixed priority and a starvation
// counter forces a waiting load through.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } src_e;

  src_e grant;

  // ALU FIFO storage and bookkeeping
  logic [ADDRESS_WIDTH-1:0] alu_rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    alu_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         alu_wr_ptr, alu_rd_ptr;
  logic [CNT_W-1:0]         alu_cnt;
  logic                     alu_push, alu_pop, alu_ne;

  // Load FIFO storage and bookkeeping
  logic [ADDRESS_WIDTH-1:0] mem_rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         mem_wr_ptr, mem_rd_ptr;
  logic [CNT_W-1:0]         mem_cnt;
  logic                     mem_push, mem_pop, mem_ne;

  logic                     contended;
  logic                     mem_priority;
  logic [ADDRESS_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0]    win_data;

  // Ready depends only on occupancy, so a full FIFO never accepts a push even if it pops that cycle
  assign alu_ready = (alu_cnt != FULL_CNT);
  assign mem_ready = (mem_cnt != FULL_CNT);
  assign alu_push  = alu_valid & alu_ready;
  assign mem_push  = mem_valid & mem_ready;
  assign alu_ne    = (alu_cnt != '0);
  assign mem_ne    = (mem_cnt != '0);
  assign alu_pop   = (grant == SRC_ALU);
  assign mem_pop   = (grant == SRC_MEM);
  assign contended = alu_ne & mem_ne;

  // ALU FIFO data array; contents need no reset because the occupancy count guards them
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_rd_mem[alu_wr_ptr]   <= alu_rd;
      alu_data_mem[alu_wr_ptr] <= alu_data;
    end
  end

  // ALU FIFO pointers and occupancy; the pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
    end else begin
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
      case ({alu_push, alu_pop})
        2'b10:   alu_cnt <= alu_cnt + CNT_W'(1);
        2'b01:   alu_cnt <= alu_cnt - CNT_W'(1);
        default: alu_cnt <= alu_cnt;
      endcase
    end
  end

  // Load FIFO data array
  always_ff @(posedge clk) begin
    if (mem_push) begin
      mem_rd_mem[mem_wr_ptr]   <= mem_rd;
      mem_data_mem[mem_wr_ptr] <= mem_data;
    end
  end

  // Load FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_ptr <= '0;
      mem_rd_ptr <= '0;
      mem_cnt    <= '0;
    end else begin
      if (mem_push) mem_wr_ptr <= mem_wr_ptr + PTR_W'(1);
      if (mem_pop)  mem_rd_ptr <= mem_rd_ptr + PTR_W'(1);
      case ({mem_push, mem_pop})
        2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

`ifdef RR_ARB_EN
  logic rr_mem;

  assign mem_priority = rr_mem;

  // Round-robin pointer: after a contended grant it points at the source that lost
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_mem <= 1'b0;
    end else if (contended) begin
      rr_mem <= (grant == SRC_ALU);
    end
  end
`else
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  logic [SW-1:0] starve;

  assign mem_priority = (starve == STARVE_MAX);

  // Starvation counter: counts the cycles a waiting load loses and saturates at the force threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (mem_ne && (grant != SRC_MEM)) begin
      if (starve != STARVE_MAX) starve <= starve + SW'(1);
    end else begin
      starve <= '0;
    end
  end
`endif

  // Pick at most one winner per cycle from the FIFO heads
  always_comb begin
    grant = SRC_NONE;
    if (contended) begin
      grant = mem_priority ? SRC_MEM : SRC_ALU;
    end else if (alu_ne) begin
      grant = SRC_ALU;
    end else if (mem_ne) begin
      grant = SRC_MEM;
    end
  end

  // Route the winning head to the write port
  always_comb begin
    win_rd   = alu_rd_mem[alu_rd_ptr];
    win_data = alu_data_mem[alu_rd_ptr];
    if (grant == SRC_MEM) begin
      win_rd   = mem_rd_mem[mem_rd_ptr];
      win_data = mem_data_mem[mem_rd_ptr];
    end
  end

  // Registered write port; writes to x0 are drained but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (grant != SRC_NONE) begin
      WE3 <= (win_rd != '0);
      AD3 <= win_rd;
      WD3 <= win_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  assign busy = alu_ne | mem_ne | WE3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized stimulus for regfile_wb_arbiter,
// checked against a queue-based reference model of the writeback arbiter.
// Honours the RR_ARB_EN build macro in the same way as the design.
module tb_regfile_wb_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int DEPTH  = 2;
  localparam int SLIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic          busy;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(SLIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .WE3(WE3),
    .AD3(AD3),
    .WD3(WD3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // Reference model: one queue per source, plus the expected write-port values
  entry_t        alu_q[$];
  entry_t        mem_q[$];
  int            starve;
  int            rr;
  logic          exp_we;
  logic [AW-1:0] exp_ad;
  logic [DW-1:0] exp_wd;
  logic          exp_busy;
  bit            ad_known;
  bit            model_valid;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model one clock edge using the inputs present before that edge
  task automatic modelStep(input bit r, input bit av, input entry_t ae, input bit mv, input entry_t me);
    bit     a_ready, m_ready, a_ne, m_ne;
    int     winner;  // 0 none, 1 alu, 2 mem
    entry_t e;
    if (r) begin
      alu_q.delete();
      mem_q.delete();
      starve      = 0;
      rr          = 0;
      exp_we      = 1'b0;
      exp_ad      = '0;
      exp_wd      = '0;
      ad_known    = 1'b1;
      model_valid = 1'b1;
    end else begin
      a_ready = alu_q.size() < DEPTH;
      m_ready = mem_q.size() < DEPTH;
      a_ne    = alu_q.size() != 0;
      m_ne    = mem_q.size() != 0;
      winner  = 0;
      if (a_ne && m_ne) begin
`ifdef RR_ARB_EN
        winner = (rr == 1) ? 2 : 1;
        rr     = (winner == 1) ? 1 : 0;
`else
        winner = (starve == SLIMIT - 1) ? 2 : 1;
`endif
      end else if (a_ne) begin
        winner = 1;
      end else if (m_ne) begin
        winner = 2;
      end
      if (m_ne && winner != 2) starve = (starve + 1 > SLIMIT - 1) ? SLIMIT - 1 : starve + 1;
      else starve = 0;
      if (winner != 0) begin
        e        = (winner == 1) ? alu_q.pop_front() : mem_q.pop_front();
        exp_we   = (e.rd != 0);
        exp_ad   = e.rd;
        exp_wd   = e.data;
        ad_known = 1'b1;
      end else begin
        exp_we   = 1'b0;
        ad_known = 1'b0;
      end
      if (av && a_ready) alu_q.push_back(ae);
      if (mv && m_ready) mem_q.push_back(me);
    end
    exp_busy = (alu_q.size() != 0) || (mem_q.size() != 0) || exp_we;
  endtask

  // Drive one cycle of inputs, check ready before the edge and the write port after it
  task automatic applyStimulus(input bit r, input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                               input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    rst       = r;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    #1;
    if (model_valid) begin
      checkOutput("alu_ready", alu_ready, alu_q.size() < DEPTH);
      checkOutput("mem_ready", mem_ready, mem_q.size() < DEPTH);
    end
    modelStep(r, av, '{rd: ard, data: ad}, mv, '{rd: mrd, data: md});
    @(posedge clk);
    #1;
    checkOutput("we3", WE3, exp_we);
    checkOutput("busy", busy, exp_busy);
    if (ad_known) begin
      checkOutput("ad3", AD3, exp_ad);
      checkOutput("wd3", WD3, exp_wd);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    model_valid = 1'b0;
    ad_known    = 1'b0;
    starve      = 0;
    rr          = 0;

    // Reset
    applyStimulus(1, 0, '0, '0, 0, '0, '0);
    applyStimulus(1, 0, '0, '0, 0, '0, '0);
    checkOutput("rst_we3", WE3, 0);
    checkOutput("rst_busy", busy, 0);

    // Single ALU write with two-edge latency
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    checkOutput("t1_we3_early", WE3, 0);
    idle(1);
    checkOutput("t1_we3", WE3, 1);
    checkOutput("t1_ad3", AD3, 5);
    checkOutput("t1_wd3", WD3, 32'hDEADBEEF);
    idle(1);
    checkOutput("t1_we3_off", WE3, 0);
    checkOutput("t1_busy_off", busy, 0);

    // Simultaneous ALU and load requests
    applyStimulus(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    idle(1);
    checkOutput("t2_first", AD3, 3);
    idle(1);
    checkOutput("t2_second", AD3, 4);
    idle(2);

    // Continuous ALU stream against a pending load
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, AW'(8 + i), 32'h100 + i, i == 0, 5'd7, 32'h77);
`ifndef RR_ARB_EN
      if (i == 4) checkOutput("t3_load_forced", AD3, 7);
      if (i == 5) checkOutput("t3_alu_resume", AD3, 11);
`endif
    end
    idle(4);

    // Back-to-back ALU pushes, written in push order
    applyStimulus(0, 1, 5'd12, 32'hA0, 0, '0, '0);
    applyStimulus(0, 1, 5'd13, 32'hA1, 0, '0, '0);
    applyStimulus(0, 1, 5'd14, 32'hA2, 0, '0, '0);
    idle(3);

    // Load to x0 drains without a write enable
    applyStimulus(0, 0, '0, '0, 1, 5'd0, 32'h1234);
    idle(1);
    checkOutput("t5_we3", WE3, 0);
    checkOutput("t5_ad3", AD3, 0);
    checkOutput("t5_wd3", WD3, 32'h1234);
    idle(1);
    checkOutput("t5_busy", busy, 0);

`ifdef RR_ARB_EN
    // Contended grants alternate from a fresh pointer
    applyStimulus(1, 0, '0, '0, 0, '0, '0);
    applyStimulus(0, 1, 5'd20, 32'h20, 1, 5'd22, 32'h22);
    applyStimulus(0, 1, 5'd21, 32'h21, 1, 5'd23, 32'h23);
    checkOutput("rr_1", AD3, 20);
    idle(1);
    checkOutput("rr_2", AD3, 22);
    idle(1);
    checkOutput("rr_3", AD3, 21);
    idle(1);
    checkOutput("rr_4", AD3, 23);
    idle(2);
`endif

    // Reset while both FIFOs hold entries
    applyStimulus(0, 1, 5'd24, 32'h24, 1, 5'd25, 32'h25);
    applyStimulus(0, 1, 5'd26, 32'h26, 1, 5'd27, 32'h27);
    applyStimulus(1, 0, '0, '0, 0, '0, '0);
    checkOutput("t6_we3", WE3, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_alu_ready", alu_ready, 1);
    checkOutput("t6_mem_ready", mem_ready, 1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      checkOutput("t6_no_ghost", WE3, 0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 79) == 0,
                    $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), DW'($urandom),
                    $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
